// File: rtl/cac5_pkg.sv
// Shared constants, codeword type and the encode / legality helpers for the
// 5-wire Fibonacci crosstalk-avoidance code.
package cac5_pkg;

  localparam int CW_W       = 5;
  localparam int CODE_COUNT = 13;
  localparam int MAX_VAL    = 12;

  // Wire weights, bit4..bit0
  localparam int W4 = 5;
  localparam int W3 = 3;
  localparam int W2 = 2;
  localparam int W1 = 1;
  localparam int W0 = 1;

  // Greedy thresholds. T3 is 5 rather than 3: taking bit3 early would force
  // an isolated 1 on bit3 when bit2/bit4 cannot follow.
  localparam int T4 = 5;
  localparam int T3 = 5;
  localparam int T2 = 2;
  localparam int T1 = 2;
  localparam int T0 = 1;

  typedef logic [CW_W-1:0] cac5_word_t;

  // Values above MAX_VAL saturate to the all-ones codeword.
  function automatic cac5_word_t cac5_encode(input logic [3:0] v);
    logic [3:0] r;
    cac5_word_t c;
    r    = (v > 4'(MAX_VAL)) ? 4'(MAX_VAL) : v;
    c[4] = (r >= 4'(T4));
    if (c[4]) r = r - 4'(W4);
    c[3] = (r >= 4'(T3));
    if (c[3]) r = r - 4'(W3);
    c[2] = (r >= 4'(T2));
    if (c[2]) r = r - 4'(W2);
    c[1] = (r >= 4'(T1));
    if (c[1]) r = r - 4'(W1);
    c[0] = (r >= 4'(T0));
    return c;
  endfunction

  // An inner wire may only be high when both of its neighbours are high.
  function automatic logic cac5_legal(input cac5_word_t w);
    return !(w[1] && !(w[0] && w[2])) && !(w[3] && !(w[2] && w[4]));
  endfunction

endpackage

// File: rtl/cac5_decoder.sv
// Receive-side decoder: weighted sum of the received wires plus legality flag.
// Purely combinational; can be used on its own at the far end of the link.
module cac5_decoder
  import cac5_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  cac5_word_t        i_tsv,
  output logic [DATA_W-1:0] o_data,
  output logic              o_code_err
);

  logic [3:0] w_sum;

  // Maximum sum is 12, so 4 bits never overflow before truncation.
  assign w_sum = (i_tsv[4] ? 4'(W4) : 4'd0)
               + (i_tsv[3] ? 4'(W3) : 4'd0)
               + (i_tsv[2] ? 4'(W2) : 4'd0)
               + (i_tsv[1] ? 4'(W1) : 4'd0)
               + (i_tsv[0] ? 4'(W0) : 4'd0);

  assign o_data     = w_sum[DATA_W-1:0];
  assign o_code_err = !cac5_legal(i_tsv);

endmodule

// File: rtl/cac_codec5.sv
// 5-wire crosstalk-avoidance codec: registered encoder onto the TSVs and a
// combinational decoder for the received wires. DATA_W is 3 or 4.
module cac_codec5
  import cac5_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data_in,
  output cac5_word_t        o_tsv_out,
  output logic              o_range_err,
  input  cac5_word_t        i_tsv_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_code_err
);

  logic [3:0] w_din;
  cac5_word_t w_code;
  logic       w_over;
  cac5_word_t r_tsv;
  logic       r_range_err;

  assign w_din  = 4'(i_data_in);
  assign w_code = cac5_encode(w_din);
  assign w_over = (w_din > 4'(MAX_VAL));

  // Reset drives the code of 0 onto the wires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tsv       <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_tsv       <= w_code;
      r_range_err <= w_over;
    end
  end

  assign o_tsv_out   = r_tsv;
  assign o_range_err = r_range_err;

  cac5_decoder #(.DATA_W(DATA_W)) u_dec (
    .i_tsv      (i_tsv_in),
    .o_data     (o_data_out),
    .o_code_err (o_code_err)
  );

endmodule

// File: tb/tb_cac_codec5.sv
// Bench for cac_codec5: one DATA_W=3 and one DATA_W=4 instance against a
// codeword-list model, plus literal expectations from the code table.
module tb_cac_codec5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       loop = 1'b1;
  logic [2:0] d3 = 3'd5;
  logic [3:0] d4 = 4'd5;
  logic [4:0] f3 = '0, f4 = '0;
  logic [4:0] to3, to4, ti3, ti4;
  logic       re3, re4, ce3, ce4;
  logic [2:0] do3;
  logic [3:0] do4;

  int n_chk = 0;
  int n_fail = 0;

  // The 13 legal words in ascending order; value v encodes to LIST[v].
  int LIST [13] = '{0, 1, 4, 5, 7, 16, 17, 20, 21, 23, 28, 29, 31};

  assign ti3 = loop ? to3 : f3;
  assign ti4 = loop ? to4 : f4;

  cac_codec5 #(.DATA_W(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_data_in(d3), .o_tsv_out(to3),
    .o_range_err(re3), .i_tsv_in(ti3), .o_data_out(do3), .o_code_err(ce3));

  cac_codec5 #(.DATA_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_data_in(d4), .o_tsv_out(to4),
    .o_range_err(re4), .i_tsv_in(ti4), .o_data_out(do4), .o_code_err(ce4));

  always #5 clk = ~clk;

  function automatic int m_code(input int v);
    return LIST[(v > 12) ? 12 : v];
  endfunction

  function automatic int m_sum(input logic [4:0] w);
    return 5 * int'(w[4]) + 3 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
  endfunction

  function automatic bit m_legal(input logic [4:0] w);
    for (int i = 0; i < 13; i++) if (int'(w) == LIST[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model state: what each edge should have captured.
  int m_tsv3 = 0, m_tsv4 = 0, m_last3 = 0, m_last4 = 0;
  bit m_re4 = 0, m_vld = 0, chk_en = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tsv3 = 0; m_tsv4 = 0; m_re4 = 0; m_vld = 0;
    end else begin
      m_last3 = int'(d3); m_last4 = int'(d4);
      m_tsv3  = m_code(m_last3);
      m_tsv4  = m_code(m_last4);
      m_re4   = (m_last4 > 12);
      m_vld   = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tsv3", 32'(to3), 32'(m_tsv3));
      chk("tsv4", 32'(to4), 32'(m_tsv4));
      chk("rerr3", 32'(re3), 32'd0);
      chk("rerr4", 32'(re4), 32'(m_re4));
      chk("dout3", 32'(do3), 32'(m_sum(ti3) % 8));
      chk("dout4", 32'(do4), 32'(m_sum(ti4) % 16));
      chk("cerr3", 32'(ce3), 32'(!m_legal(ti3)));
      chk("cerr4", 32'(ce4), 32'(!m_legal(ti4)));
      chk("legal4", 32'(m_legal(to4)), 32'd1);
      if (loop && m_vld) begin
        chk("loop3", 32'(do3), 32'(m_last3));
        if (m_last4 <= 12) chk("loop4", 32'(do4), 32'(m_last4));
      end
    end
  end

  logic [4:0] cap3 [8];
  logic [4:0] cap4 [13];
  int E3 [8] = '{0, 1, 4, 5, 7, 16, 17, 20};

  task automatic step(input logic [2:0] a, input logic [3:0] b);
    @(negedge clk); #1;
    d3 = a; d4 = b;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with no edge: outputs forced at once.
    #2 rst = 1'b1;
    #1;
    chk("rst_tsv3", 32'(to3), 32'd0);
    chk("rst_tsv4", 32'(to4), 32'd0);
    chk("rst_rerr4", 32'(re4), 32'd0);
    chk_en = 1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Ascending sweep in loopback
    for (int v = 0; v < 13; v++) begin
      step(3'(v < 8 ? v : 0), 4'(v));
      if (v < 8) cap3[v] = to3;
      cap4[v] = to4;
    end
    for (int v = 0; v < 8; v++) chk("sweep3", 32'(cap3[v]), 32'(E3[v]));
    for (int v = 0; v < 13; v++) chk("sweep4", 32'(cap4[v]), 32'(LIST[v]));
    chk("ex8", 32'(cap4[8]), 32'b10101);
    chk("ex10", 32'(cap4[10]), 32'b11100);

    // Out-of-range input saturates and flags for one cycle
    step(3'd0, 4'd14);
    chk("rng_tsv", 32'(to4), 32'b11111);
    chk("rng_err", 32'(re4), 32'd1);
    step(3'd0, 4'd3);
    chk("rng_tsv2", 32'(to4), 32'b00101);
    chk("rng_err2", 32'(re4), 32'd0);

    // Illegal received words
    @(negedge clk); #1;
    loop = 1'b0; f3 = 5'b01000; f4 = 5'b01000;
    #1;
    chk("ill_d3", 32'(do3), 32'd3);
    chk("ill_d4", 32'(do4), 32'd3);
    chk("ill_e4", 32'(ce4), 32'd1);
    f3 = 5'b00010; f4 = 5'b00010;
    #1;
    chk("ill2_d4", 32'(do4), 32'd1);
    chk("ill2_e3", 32'(ce3), 32'd1);
    f4 = 5'b11111;
    #1;
    chk("full_d4", 32'(do4), 32'd12);
    step(3'd1, 4'd1);
    loop = 1'b1;

    // Mid-stream reset drops the pending word
    step(3'd6, 4'd9);
    @(negedge clk); d3 = 3'd7; d4 = 4'd11;
    #2 rst = 1'b1;
    #1;
    chk("mrst_tsv4", 32'(to4), 32'd0);
    chk("mrst_tsv3", 32'(to3), 32'd0);
    @(negedge clk); #1 rst = 1'b0;

    // Wrapping count
    for (int i = 0; i < 100; i++) step(3'(i % 8), 4'(i % 16));
    @(negedge clk); #1;

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
